// File: rtl/crypto_test_sysid_checker_pkg.sv
// Shared constants for the sysid checker: FSM state codes, default ID/timestamp, timer width.
// Optional timestamp check is enabled by defining CRYPTO_TEST_SYSID_CHECK_TS_EN.
package crypto_test_sysid_checker_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ID_REQ  = 3'd1;
  localparam logic [2:0] ST_ID_WAIT = 3'd2;
  localparam logic [2:0] ST_TS_REQ  = 3'd3;
  localparam logic [2:0] ST_TS_WAIT = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h1234_5678;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5510_DB22;

  localparam int TMR_W = 16;

endpackage

// File: rtl/crypto_test_sysid_rd_timer.sv
// Per-read timeout counter: cleared on entry to a request state, counts while enabled.
// expired is high in the cycle that would bring the count to TIMEOUT_CYCLES.
module crypto_test_sysid_rd_timer
  import crypto_test_sysid_checker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/crypto_test_sysid_checker.sv
// Reads the sysid slave (ID word, and timestamp word when CRYPTO_TEST_SYSID_CHECK_TS_EN
// is defined) over Avalon-MM and compares against the expected values.
module crypto_test_sysid_checker
  import crypto_test_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [2:0]  dbg_state
);

  // Handshake: a read command is accepted on a rising edge where avm_read=1 and
  // avm_waitrequest=0; avm_read/avm_address are held unchanged until then. Response
  // data is taken only on an edge where avm_readdatavalid=1 while in a *_WAIT state.

  logic [2:0] state;
  logic [2:0] next_state;
  logic       tmr_clear;
  logic       tmr_en;
  logic       tmr_expired;
  logic       tmo_set;

  always_comb begin
    next_state = state;
    tmr_en     = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_ID_REQ;
      end
      ST_ID_REQ: begin
        tmr_en = 1'b1;
        // Budget exhaustion wins over a late grant so the read never exceeds its budget.
        if (tmr_expired) begin
          next_state = ST_FINISH;
          tmo_set    = 1'b1;
        end else if (!avm_waitrequest) begin
          next_state = ST_ID_WAIT;
        end
      end
      ST_ID_WAIT: begin
        tmr_en = 1'b1;
        if (avm_readdatavalid) begin
`ifdef CRYPTO_TEST_SYSID_CHECK_TS_EN
          next_state = ST_TS_REQ;
`else
          next_state = ST_FINISH;
`endif
        end else if (tmr_expired) begin
          next_state = ST_FINISH;
          tmo_set    = 1'b1;
        end
      end
`ifdef CRYPTO_TEST_SYSID_CHECK_TS_EN
      ST_TS_REQ: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          next_state = ST_FINISH;
          tmo_set    = 1'b1;
        end else if (!avm_waitrequest) begin
          next_state = ST_TS_WAIT;
        end
      end
      ST_TS_WAIT: begin
        tmr_en = 1'b1;
        if (avm_readdatavalid) begin
          next_state = ST_FINISH;
        end else if (tmr_expired) begin
          next_state = ST_FINISH;
          tmo_set    = 1'b1;
        end
      end
`endif
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign tmr_clear = ((next_state == ST_ID_REQ) && (state != ST_ID_REQ)) ||
                     ((next_state == ST_TS_REQ) && (state != ST_TS_REQ));

  crypto_test_sysid_rd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
    end else begin
      state <= next_state;
      done  <= (state == ST_FINISH);
      if ((state == ST_IDLE) && start) begin
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end
      if ((state == ST_ID_WAIT) && avm_readdatavalid) begin
        captured_id <= avm_readdata;
        id_mismatch <= (avm_readdata != EXPECTED_ID);
      end
      if (tmo_set) timeout <= 1'b1;
      if (state == ST_FINISH) pass <= !(id_mismatch | ts_mismatch | timeout);
    end
  end

`ifdef CRYPTO_TEST_SYSID_CHECK_TS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_mismatch <= 1'b0;
      captured_ts <= '0;
    end else begin
      if ((state == ST_IDLE) && start) ts_mismatch <= 1'b0;
      if ((state == ST_TS_WAIT) && avm_readdatavalid) begin
        captured_ts <= avm_readdata;
        ts_mismatch <= (avm_readdata != EXPECTED_TS);
      end
    end
  end
`else
  assign ts_mismatch = 1'b0;
  assign captured_ts = '0;
`endif

  assign avm_read    = (state == ST_ID_REQ) || (state == ST_TS_REQ);
  assign avm_address = (state == ST_TS_REQ);
  assign busy        = (state != ST_IDLE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_crypto_test_sysid_checker.sv
// Bench for crypto_test_sysid_checker: reactive Avalon slave, transaction-level model,
// per-cycle scoreboard. Follows CRYPTO_TEST_SYSID_CHECK_TS_EN like the design.
module tb_crypto_test_sysid_checker;

  localparam int T = 5;
`ifdef CRYPTO_TEST_SYSID_CHECK_TS_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif
  localparam logic [31:0] EXP_ID = 32'h1234_5678;
  localparam logic [31:0] EXP_TS = 32'h5510_DB22;
  localparam int GAP = 8;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        id_mismatch;
  logic        ts_mismatch;
  logic        timeout;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;
  logic [2:0]  dbg_state;

  crypto_test_sysid_checker #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_mismatch       (id_mismatch),
    .ts_mismatch       (ts_mismatch),
    .timeout           (timeout),
    .captured_id       (captured_id),
    .captured_ts       (captured_ts),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  // entry bits: {check_status, busy, done, avm_read, avm_address}
  logic [4:0]  exp_q[$];
  logic        m_pass, m_idm, m_tsm, m_tmo;
  logic [31:0] m_cid, m_cts;
  int          tests;
  int          fails;
  bit          checking;
  bit          run_active;
  int          plan_w[2];
  int          plan_l[2];
  logic [31:0] plan_d[2];

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin : compare
    logic [4:0] e;
    if (checking) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 5'b10000;
      check_bit("busy", busy, e[3]);
      check_bit("done", done, e[2]);
      check_bit("avm_read", avm_read, e[1]);
      if (e[1]) check_bit("avm_address", avm_address, e[0]);
      if (e[4]) begin
        check_bit("pass", pass, m_pass);
        check_bit("id_mismatch", id_mismatch, m_idm);
        check_bit("ts_mismatch", ts_mismatch, m_tsm);
        check_bit("timeout", timeout, m_tmo);
        check_word("captured_id", captured_id, m_cid);
        check_word("captured_ts", captured_ts, m_cts);
      end
    end
  end

  // ---------------- reactive slave ----------------
  initial begin : slave
    int          wait_left;
    int          lat_left;
    int          idx;
    bit          in_cmd;
    bit          pending;
    logic [31:0] resp;
    wait_left = 0; lat_left = 0; in_cmd = 0; pending = 0; resp = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (pending) begin
        lat_left--;
        if (lat_left == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = resp;
          pending           = 0;
        end
      end else if (!run_active && ($urandom_range(0, 3) == 0)) begin
        avm_readdatavalid = 1'b1;
      end
      if (avm_read) begin
        idx = avm_address ? 1 : 0;
        if (!in_cmd) begin
          in_cmd    = 1;
          wait_left = plan_w[idx];
        end
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          in_cmd          = 0;
          if (plan_l[idx] != 0) begin
            pending  = 1;
            lat_left = plan_l[idx];
            resp     = plan_d[idx];
          end
        end
      end else begin
        in_cmd          = 0;
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver + model ----------------
  // A word succeeds when (waitrequest cycles + 1) + response latency fits in T cycles;
  // otherwise that read burns exactly T cycles and the check ends with a timeout.
  task automatic run_check(input int w0, input int l0, input logic [31:0] d0,
                           input int w1, input int l1, input logic [31:0] d1,
                           input bit extra, output int lat);
    int          w[2];
    int          l[2];
    logic [31:0] d[2];
    int          s;
    int          extra_at;
    bit          to;
    logic        idm, tsm;
    logic [31:0] cid, cts;
    w[0] = w0; w[1] = w1; l[0] = l0; l[1] = l1; d[0] = d0; d[1] = d1;
    s = 0; to = 0; idm = 1'b0; tsm = 1'b0; cid = m_cid; cts = m_cts;
    exp_q.push_back(5'b00000);
    for (int i = 0; i < NW && !to; i++) begin
      int r;
      int dur;
      bit ok;
      r   = w[i] + 1;
      ok  = (l[i] != 0) && (r + l[i] <= T);
      dur = ok ? r + l[i] : T;
      for (int c = 1; c <= dur; c++) exp_q.push_back({1'b0, 1'b1, 1'b0, (c <= r), (i == 1)});
      if (!ok) to = 1;
      else if (i == 0) begin cid = d[0]; idm = (d[0] != EXP_ID); end
      else begin cts = d[1]; tsm = (d[1] != EXP_TS); end
      s += dur;
    end
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b10100);
    m_cid = cid; m_cts = cts; m_idm = idm; m_tsm = tsm; m_tmo = to;
    m_pass = !(idm | tsm | to);

    extra_at = extra ? $urandom_range(1, s + 1) : -1;
    for (int i = 0; i < 2; i++) begin plan_w[i] = w[i]; plan_l[i] = l[i]; plan_d[i] = d[i]; end
    run_active = 1;
    lat = -1;
    start = 1'b1;
    for (int k = 0; k < s + 2 + GAP; k++) begin
      @(posedge clock);
      #1;
      if (done && lat < 0) lat = k;
      start = ((k + 1) == extra_at);
      if (k >= s + 2) run_active = 0;
    end
    start = 1'b0;
    run_active = 0;
  endtask

  initial begin : main
    int lat;
    int w0, w1, l0, l1;
    logic [31:0] d0, d1;
    tests = 0; fails = 0; checking = 0; run_active = 0;
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin plan_w[i] = 0; plan_l[i] = 1; plan_d[i] = '0; end
    m_pass = 0; m_idm = 0; m_tsm = 0; m_tmo = 0; m_cid = '0; m_cts = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checking = 1;
    repeat (3) @(posedge clock);
    #1;

    // zero-wait, correct values: minimum latency and pass
    run_check(0, 1, EXP_ID, 0, 1, EXP_TS, 0, lat);
    check_word("min_latency", lat, (NW == 2) ? 32'd5 : 32'd3);
    check_bit("pass_good", pass, 1'b1);

    // wrong ID: TS read still performed
    run_check(0, 1, 32'h1234_5679, 0, 1, EXP_TS, 0, lat);
    check_bit("idm_bad", id_mismatch, 1'b1);
    check_bit("pass_bad", pass, 1'b0);
    check_word("cid_bad", captured_id, 32'h1234_5679);

    // waitrequest held 3 cycles on word 1, plus a start while busy
    run_check(0, 1, EXP_ID, 3, 1, EXP_TS, 1, lat);
    check_bit("pass_wait", pass, 1'b1);

    // slave never responds: timeout after T cycles
    run_check(0, 0, EXP_ID, 0, 1, EXP_TS, 0, lat);
    check_word("tmo_latency", lat, 32'd6);
    check_bit("tmo_flag", timeout, 1'b1);
    check_bit("tmo_pass", pass, 1'b0);

    // response on the expiry cycle is accepted
    run_check(0, T - 1, EXP_ID, 0, 1, EXP_TS, 0, lat);
    check_bit("edge_tmo", timeout, 1'b0);
    check_bit("edge_pass", pass, 1'b1);

    // waitrequest outlasts the budget
    run_check(6, 1, EXP_ID, 0, 1, EXP_TS, 0, lat);
    check_bit("req_tmo", timeout, 1'b1);

    // reset while waiting for ID data; the late response must be ignored
    plan_w[0] = 0; plan_l[0] = 3; plan_d[0] = EXP_ID;
    run_active = 1;
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b01010);
    exp_q.push_back(5'b01000);
    m_pass = 0; m_idm = 0; m_tsm = 0; m_tmo = 0; m_cid = '0; m_cts = '0;
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    repeat (GAP) begin @(posedge clock); #1; end
    run_active = 0;
    check_word("rst_cid", captured_id, 32'h0);
    check_bit("rst_done", done, 1'b0);
    run_check(0, 1, EXP_ID, 0, 1, EXP_TS, 0, lat);
    check_bit("post_rst_pass", pass, 1'b1);

    // randomized runs
    for (int n = 0; n < 40; n++) begin
      w0 = $urandom_range(0, 5); l0 = $urandom_range(0, 4);
      w1 = $urandom_range(0, 5); l1 = $urandom_range(0, 4);
      d0 = ($urandom_range(0, 2) == 0) ? (EXP_ID ^ (32'h1 << $urandom_range(0, 31))) : EXP_ID;
      d1 = ($urandom_range(0, 2) == 0) ? (EXP_TS ^ (32'h1 << $urandom_range(0, 31))) : EXP_TS;
      run_check(w0, l0, d0, w1, l1, d1, 1'($urandom_range(0, 1)), lat);
    end

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
